// File: rtl/qnigma_tcp_tx_queue_pkg.sv
// Shared types for the TCP TX descriptor queue: the packet descriptor,
// the scan engine state encoding and width helpers derived from depth.
package qnigma_tcp_tx_queue_pkg;

    // Transmitted-packet descriptor kept until the peer acknowledges it
    typedef struct packed {
        logic [31:0] seq;    // first sequence number of the segment
        logic [15:0] len;    // payload length in bytes
        logic [7:0]  tries;  // retransmission attempts so far
    } tcp_pkt_t;

    // Scan engine states: waiting for entries, RAM read in flight, entry presented
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SHOW = 2'd2
    } tcp_txq_scan_t;

    localparam int TXQ_DEF_D = 4;

    // Occupancy counter width: one extra bit so all 2^D slots are usable
    function automatic int txq_cnt_w(input int d);
        return d + 1;
    endfunction

endpackage

// File: rtl/qnigma_tcp_tx_queue_if.sv
// Bundle between the TX control/retransmission logic and the descriptor queue.
// master: the users of the queue; slave: the queue itself.
interface qnigma_tcp_tx_queue_if
    import qnigma_tcp_tx_queue_pkg::*;
#(
    parameter int D = TXQ_DEF_D,
    parameter int W = $bits(tcp_pkt_t)
);
    logic                       add;
    logic [W-1:0]               add_pkt;
    logic                       free;
    logic                       scan_v;
    logic                       scan_rdy;
    logic [D-1:0]               scan_ptr;
    logic [W-1:0]               scan_pkt;
    logic                       upd;
    logic [W-1:0]               upd_pkt;
    logic [txq_cnt_w(D)-1:0]    count;
    logic                       empty;
    logic                       full;

    modport master (
        output add, add_pkt, free, scan_rdy, upd, upd_pkt,
        input  scan_v, scan_ptr, scan_pkt, count, empty, full
    );

    modport slave (
        input  add, add_pkt, free, scan_rdy, upd, upd_pkt,
        output scan_v, scan_ptr, scan_pkt, count, empty, full
    );
endinterface

// File: rtl/qnigma_tcp_tx_queue_ram_dp.sv
// Dual-port descriptor storage: port A write-only, port B read/write with a
// registered read. Both ports share one process so the array has one driver;
// callers guarantee the two write addresses never collide.
module qnigma_tcp_tx_queue_ram_dp #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout
);
    logic [DW-1:0] mem [2**AW];

    // Writes on both ports plus the port-B registered read
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (b_we) begin
            mem[b_addr] <= b_din;
        end
        b_dout <= mem[b_addr];
    end
endmodule

// File: rtl/qnigma_tcp_tx_queue.sv
// In-order queue of transmitted TCP descriptors. Control pushes at the tail
// and frees at the head; a scan engine walks the occupied region head->tail
// repeatedly, presenting each entry and accepting in-place updates.
module qnigma_tcp_tx_queue
    import qnigma_tcp_tx_queue_pkg::*;
#(
    parameter int D = TXQ_DEF_D,
    parameter int W = $bits(tcp_pkt_t)
) (
    input  logic                    clk,
    input  logic                    rst,
    qnigma_tcp_tx_queue_if.slave    bus
);
    localparam logic [D:0] CNT_ZERO = '0;
    localparam logic [D:0] CNT_ONE  = {{D{1'b0}}, 1'b1};
    localparam logic [D:0] CNT_FULL = {1'b1, {D{1'b0}}};
    localparam logic [D:0] CNT_LAST = {1'b0, {D{1'b1}}};

    logic [D-1:0]   head_reg, head_next;
    logic [D-1:0]   tail_reg, tail_next;
    logic [D:0]     count_reg, count_next;
    tcp_txq_scan_t  state_reg, state_next;
    logic [D-1:0]   scan_ptr_reg, scan_ptr_next;
    logic [W-1:0]   hold_reg, hold_next;
    logic           use_hold_reg, use_hold_next;

    logic           add_acc;
    logic           free_acc;
    logic           head_lost;
    logic [D-1:0]   step_ptr;
    logic           b_we;
    logic [D-1:0]   b_addr;
    logic [W-1:0]   ram_q;

    assign add_acc   = bus.add  && (count_reg != CNT_FULL);
    assign free_acc  = bus.free && (count_reg != CNT_ZERO);
    // The entry under the scan is being popped this cycle
    assign head_lost = free_acc && (scan_ptr_reg == head_reg);
    assign step_ptr  = scan_ptr_reg + D'(1);

    // Head/tail pointers and occupancy for this cycle's accepted events
    always_comb begin
        head_next  = head_reg + D'(free_acc);
        tail_next  = tail_reg + D'(add_acc);
        count_next = count_reg;
        if (add_acc && !free_acc) begin
            count_next = count_reg + CNT_ONE;
        end else if (free_acc && !add_acc) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Scan engine next state, RAM port-B control and presented-copy shadow
    always_comb begin
        state_next    = state_reg;
        scan_ptr_next = scan_ptr_reg;
        hold_next     = hold_reg;
        use_hold_next = use_hold_reg;
        b_we          = 1'b0;
        b_addr        = scan_ptr_reg;
        case (state_reg)
            IDLE: begin
                b_addr = head_reg;
                // Start at the head as it will be after any pop this cycle
                if (count_reg != CNT_ZERO && count_next != CNT_ZERO) begin
                    state_next    = READ;
                    scan_ptr_next = head_next;
                end
            end
            READ: begin
                // RAM output lands next edge; present it directly from the RAM
                use_hold_next = 1'b0;
                if (head_lost) begin
                    if (count_next == CNT_ZERO) begin
                        state_next = IDLE;
                    end
                    scan_ptr_next = head_next;
                end else begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (head_lost) begin
                    // Presented entry vanished: restart at the new head, drop any update
                    state_next    = (count_next == CNT_ZERO) ? IDLE : READ;
                    scan_ptr_next = head_next;
                end else begin
                    if (bus.upd) begin
                        b_we          = 1'b1;
                        hold_next     = bus.upd_pkt;
                        use_hold_next = 1'b1;
                    end
                    if (bus.scan_rdy) begin
                        // End of occupied region is judged against the post-add tail
                        scan_ptr_next = (step_ptr == tail_next) ? head_next : step_ptr;
                        state_next    = (count_next == CNT_ZERO) ? IDLE : READ;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == IDLE && state_reg != IDLE) begin
            hold_next     = '0;
            use_hold_next = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            state_reg    <= IDLE;
            scan_ptr_reg <= '0;
            hold_reg     <= '0;
            use_hold_reg <= 1'b1;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            state_reg    <= state_next;
            scan_ptr_reg <= scan_ptr_next;
            hold_reg     <= hold_next;
            use_hold_reg <= use_hold_next;
        end
    end

    qnigma_tcp_tx_queue_ram_dp #(
        .AW (D),
        .DW (W)
    ) u_ram (
        .clk    (clk),
        .a_we   (add_acc),
        .a_addr (tail_reg),
        .a_din  (bus.add_pkt),
        .b_we   (b_we),
        .b_addr (b_addr),
        .b_din  (bus.upd_pkt),
        .b_dout (ram_q)
    );

    assign bus.scan_v   = (state_reg == SHOW);
    assign bus.scan_ptr = scan_ptr_reg;
    assign bus.scan_pkt = use_hold_reg ? hold_reg : ram_q;
    assign bus.count    = count_reg;
    assign bus.empty    = (count_reg == CNT_ZERO);
    // Look-ahead full so the producer can stop on the filling cycle
    assign bus.full     = (count_reg == CNT_FULL) || (count_reg == CNT_LAST && bus.add);

endmodule

// File: tb/tb_qnigma_tcp_tx_queue.sv
// Bench for the TCP TX descriptor queue (D=2): directed scenarios followed by
// random traffic, all checked against a queue-of-descriptors reference.
module tb_qnigma_tcp_tx_queue;
    localparam int D = 2;
    localparam int W = 32;
    localparam int N = 1 << D;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] mq[$];     // reference: outstanding descriptors, head first
    int           head_a;    // reference: address of the head descriptor
    logic         sv_s;
    logic [D-1:0] sp_s;

    qnigma_tcp_tx_queue_if #(.D(D), .W(W)) bus_if();

    qnigma_tcp_tx_queue #(.D(D), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Negedge sampling: compare status and presented entry with the reference
    task automatic obs();
        int off;
        @(negedge clk);
        sv_s = bus_if.scan_v;
        sp_s = bus_if.scan_ptr;
        if (!rst) begin
            chk("count", 64'(bus_if.count), 64'(mq.size()));
            chk("empty", 64'(bus_if.empty), 64'(mq.size() == 0));
            chk("full", 64'(bus_if.full),
                64'((mq.size() == N) || (mq.size() == N - 1 && bus_if.add)));
            if (bus_if.scan_v) begin
                off = (int'(sp_s) - head_a + N) % N;
                chk("scan_in_range", 64'(off < mq.size()), 64'd1);
                if (off < mq.size()) chk("scan_pkt", 64'(bus_if.scan_pkt), 64'(mq[off]));
            end
        end
    endtask

    // Posedge: apply this cycle's accepted events to the reference
    task automatic adv();
        bit add_acc, free_acc;
        int off;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            head_a = 0;
        end else begin
            add_acc  = bus_if.add && (mq.size() != N);
            free_acc = bus_if.free && (mq.size() != 0);
            if (bus_if.upd && sv_s) begin
                off = (int'(sp_s) - head_a + N) % N;
                if (!(free_acc && off == 0) && off < mq.size()) mq[off] = bus_if.upd_pkt;
            end
            if (free_acc) begin
                void'(mq.pop_front());
                head_a = (head_a + 1) % N;
            end
            if (add_acc) mq.push_back(bus_if.add_pkt);
        end
        #1;
    endtask

    task automatic wait_show(input string tag);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            obs();
            if (bus_if.scan_v) found = 1;
            else adv();
        end
        chk({tag, "_timeout"}, 64'(found), 64'd1);
    endtask

    // From a presented entry: release it, expect one blank cycle, then the next entry
    task automatic next_entry(input string tag);
        bus_if.scan_rdy = 1'b1;
        adv();
        bus_if.scan_rdy = 1'b0;
        obs();
        chk({tag, "_gap"}, 64'(bus_if.scan_v), 64'd0);
        adv();
        obs();
        chk({tag, "_v"}, 64'(bus_if.scan_v), 64'd1);
    endtask

    initial begin
        logic [W-1:0] exp_order [3];
        logic [W-1:0] p0, p1;
        exp_order[0] = 32'd2; exp_order[1] = 32'd3; exp_order[2] = 32'd1;
        head_a = 0;
        rst = 1'b1;
        bus_if.add = 0; bus_if.add_pkt = '0; bus_if.free = 0;
        bus_if.scan_rdy = 0; bus_if.upd = 0; bus_if.upd_pkt = '0;
        obs(); adv(); obs(); adv();
        rst = 1'b0;

        // Reset state
        obs();
        chk("rst_count", 64'(bus_if.count), 64'd0);
        chk("rst_empty", 64'(bus_if.empty), 64'd1);
        chk("rst_full", 64'(bus_if.full), 64'd0);
        chk("rst_scan_v", 64'(bus_if.scan_v), 64'd0);
        chk("rst_scan_pkt", 64'(bus_if.scan_pkt), 64'd0);
        adv();

        // Fill to capacity, overfill, drain, overdrain
        for (int i = 1; i <= 4; i++) begin
            bus_if.add = 1'b1; bus_if.add_pkt = 32'(i);
            obs();
            if (i == 4) chk("full_lookahead", 64'(bus_if.full), 64'd1);
            adv();
        end
        bus_if.add_pkt = 32'd5;
        obs();
        chk("fill_count", 64'(bus_if.count), 64'd4);
        chk("fill_full", 64'(bus_if.full), 64'd1);
        adv();
        bus_if.add = 1'b0;
        obs();
        chk("add5_ignored", 64'(bus_if.count), 64'd4);
        adv();
        for (int i = 0; i < 4; i++) begin
            bus_if.free = 1'b1; obs(); adv();
        end
        obs();
        chk("drain_empty", 64'(bus_if.empty), 64'd1);
        adv();
        bus_if.free = 1'b0;
        obs();
        chk("free5_ignored", 64'(bus_if.count), 64'd0);
        adv();

        // Scan order with wrap
        for (int i = 1; i <= 3; i++) begin
            bus_if.add = 1'b1; bus_if.add_pkt = 32'(i); obs(); adv();
        end
        bus_if.add = 1'b0;
        wait_show("order_start");
        chk("order_first", 64'(bus_if.scan_pkt), 64'd1);
        for (int k = 0; k < 3; k++) begin
            next_entry("order");
            chk("order_pkt", 64'(bus_if.scan_pkt), 64'(exp_order[k]));
        end

        // In-place update of pkt 2
        next_entry("upd_pre");
        chk("upd_pre_pkt", 64'(bus_if.scan_pkt), 64'd2);
        bus_if.upd = 1'b1; bus_if.upd_pkt = 32'hAA;
        adv();
        bus_if.upd = 1'b0;
        obs();
        chk("upd_now", 64'(bus_if.scan_pkt), 64'hAA);
        next_entry("upd_walk");
        chk("upd_walk3", 64'(bus_if.scan_pkt), 64'd3);
        next_entry("upd_walk");
        chk("upd_walk1", 64'(bus_if.scan_pkt), 64'd1);
        next_entry("upd_back");
        chk("upd_readback", 64'(bus_if.scan_pkt), 64'hAA);
        next_entry("upd_walk");
        next_entry("upd_walk");
        chk("head_present", 64'(bus_if.scan_pkt), 64'd1);

        // Free the presented head entry
        bus_if.free = 1'b1;
        adv();
        bus_if.free = 1'b0;
        obs();
        chk("headfree_drop", 64'(bus_if.scan_v), 64'd0);
        chk("headfree_count", 64'(bus_if.count), 64'd2);
        adv();
        obs();
        chk("headfree_v", 64'(bus_if.scan_v), 64'd1);
        chk("headfree_next", 64'(bus_if.scan_pkt), 64'hAA);

        // Steady occupancy 2 while pointers wrap
        for (int i = 0; i < 10; i++) begin
            bus_if.add = 1'b1; bus_if.free = 1'b1; bus_if.add_pkt = 32'(100 + i);
            adv();
            obs();
            chk("wrap_count", 64'(bus_if.count), 64'd2);
        end
        bus_if.add = 1'b0; bus_if.free = 1'b0;
        adv();
        wait_show("wrap");
        p0 = bus_if.scan_pkt;
        next_entry("wrap");
        p1 = bus_if.scan_pkt;
        chk("wrap_pair", 64'((p0 == 108 && p1 == 109) || (p0 == 109 && p1 == 108)), 64'd1);

        // Reset while presenting with three entries outstanding
        bus_if.add = 1'b1; bus_if.add_pkt = 32'd200;
        adv();
        bus_if.add = 1'b0;
        obs();
        chk("prerst_count", 64'(bus_if.count), 64'd3);
        chk("prerst_v", 64'(bus_if.scan_v), 64'd1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        obs();
        chk("midrst_count", 64'(bus_if.count), 64'd0);
        chk("midrst_empty", 64'(bus_if.empty), 64'd1);
        chk("midrst_v", 64'(bus_if.scan_v), 64'd0);
        chk("midrst_pkt", 64'(bus_if.scan_pkt), 64'd0);
        adv();
        bus_if.add = 1'b1; bus_if.add_pkt = 32'h55;
        obs(); adv();
        bus_if.add = 1'b0;
        wait_show("postrst");
        chk("postrst_ptr", 64'(bus_if.scan_ptr), 64'd0);
        chk("postrst_pkt", 64'(bus_if.scan_pkt), 64'h55);
        adv();

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            bus_if.add      = ($urandom_range(99) < 50);
            bus_if.add_pkt  = $urandom;
            bus_if.free     = ($urandom_range(99) < 40);
            bus_if.scan_rdy = ($urandom_range(99) < 50);
            bus_if.upd      = ($urandom_range(99) < 25);
            bus_if.upd_pkt  = $urandom;
            obs();
            adv();
        end
        bus_if.add = 0; bus_if.free = 0; bus_if.scan_rdy = 0; bus_if.upd = 0;
        obs(); adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
